// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default parameters and divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int DEF_CLK_FREQ   = 100_000_000;
  localparam int DEF_BAUD_RATE  = 115_200;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BIT   = 8;
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide-by-DIV oversample tick generator with synchronous clear
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  assign tick = (r_cnt == W'(DIV - 1));
  // count up to DIV-1 and wrap; clr realigns the tick grid to a start edge
  always_ff @(posedge clk)
    if (reset || clr) r_cnt <= '0;
    else r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART receiver with majority voting and a one-byte holding register
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BIT   = DEF_DATA_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [DATA_BIT-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [PW-1:0] P_S0  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] P_S1  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] P_DEC = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] P_END = PW'(OVERSAMPLE - 1);
  rx_state_t r_state, w_next;
  logic [1:0] r_sync, r_samp;
  logic [PW-1:0] r_phase;
  logic [BW-1:0] r_bit;
  logic [DATA_BIT-1:0] r_shift, r_data;
  logic r_valid, r_ferr, r_ovr;
  logic w_rx_s, w_tick, w_clr, w_dec, w_end, w_maj, w_done, w_ferr;
  assign w_rx_s = r_sync[1];
  assign w_dec  = w_tick && (r_phase == P_DEC);
  assign w_end  = w_tick && (r_phase == P_END);
  assign w_maj  = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != IDLE);
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .tick (w_tick)
  );
  // two-flop synchronizer, idling high so reset never looks like a start bit
  always_ff @(posedge clk)
    if (reset) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], rx};
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  // next state and frame strobes; the third vote is taken live on the decision tick
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_done = 1'b0;
    w_ferr = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr  = !w_rx_s;
        w_next = w_rx_s ? IDLE : START;
      end
      START:     w_next = (w_dec && w_maj) ? IDLE : w_end ? DATA : START;
      DATA:      w_next = (w_end && r_bit == BW'(DATA_BIT - 1)) ? STOP : DATA;
      STOP: begin
        w_done = w_dec && w_maj;
        w_ferr = w_dec && !w_maj;
        w_next = !w_dec ? STOP : w_maj ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: w_next = w_rx_s ? IDLE : WAIT_IDLE;
      default:   w_next = IDLE;
    endcase
  end
  // bit phase, vote samples, LSB-first shifting and data bit count
  always_ff @(posedge clk)
    if (reset) begin
      r_phase <= '0;
      r_samp  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (w_clr) begin
      r_phase <= '0;
      r_bit   <= '0;
    end else if (w_tick && r_state != IDLE) begin
      r_phase <= (r_phase == P_END) ? '0 : r_phase + 1'b1;
      if (r_phase == P_S0) r_samp[0] <= w_rx_s;
      if (r_phase == P_S1) r_samp[1] <= w_rx_s;
      if (r_state == DATA && r_phase == P_DEC) r_shift <= {w_maj, r_shift[DATA_BIT-1:1]};
      if (r_state == DATA && r_phase == P_END) r_bit <= r_bit + 1'b1;
    end
  // holding register with ready/valid handshake, overrun and frame error pulses
  always_ff @(posedge clk)
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_done && r_valid && !rx_ready;
      if (w_done && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (rx_ready) r_valid <= 1'b0;
    end
endmodule
